remote_cmd_seq: RTL and testbench

//  Parametrised successor to the remote command sender on the bluetooth/UART link.

---
 rtl/remote_cmd_pkg.sv | 5 +
 rtl/remote_cmd_seq_fifo.sv | 49 ++++
 rtl/remote_cmd_seq.sv | 202 ++++++++++++++++++++
 tb/tb_remote_cmd_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_cmd_pkg.sv
// Shared state encoding and defaults for the remote command sequencer.
package remote_cmd_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_TX, WAIT_RSP, RETRY} state_t;
   localparam logic [7:0] ACK_DEFAULT = 8'hA5;
endpackage

// File: rtl/remote_cmd_seq_fifo.sv
// Synchronous command FIFO; the wrap bit on each pointer separates full from empty.
module cmd_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty,
   output logic         o_ovf
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         r_ovf;
   logic         w_do_push;
   logic         w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
   assign o_ovf     = r_ovf;

   // Fullness is judged before this cycle's pop, so a push onto a full FIFO is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_ovf <= i_push & o_full;
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end
endmodule

// File: rtl/remote_cmd_seq.sv
// Queued command sender: bytes out MSB first over a UART, ACK/NAK/timeout with bounded resends.
// Optional REMOTE_CMD_STATS_EN adds saturating ack/fail/resend counters.
module remote_cmd_seq
   import remote_cmd_pkg::*;
#(
   parameter int         CMD_W       = 16,
   parameter int         DEPTH       = 4,
   parameter logic [7:0] ACK_BYTE    = ACK_DEFAULT,
   parameter int         TIMEOUT_CYC = 2**20,
   parameter int         MAX_RETRY   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CMD_W-1:0] i_cmd,
   input  logic             i_send_cmd,
   output logic             o_cmd_full,
   output logic             o_cmd_empty,
   output logic             o_ovf,
   output logic             o_busy,
   output logic             o_trmt,
   output logic [7:0]       o_tx_data,
   input  logic             i_tx_done,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_rdy,
   output logic             o_clr_rx_rdy,
   output logic             o_cmd_sent,
   output logic [7:0]       o_resp,
   output logic             o_resp_rdy,
   output logic             o_cmd_fail
`ifdef REMOTE_CMD_STATS_EN
   ,
   output logic [15:0]      o_ack_cnt,
   output logic [15:0]      o_fail_cnt,
   output logic [15:0]      o_retry_tot
`endif
);
   localparam int NBYTES = CMD_W / 8;
   localparam int BIW    = $clog2(NBYTES) + 1;
   localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [BIW-1:0] LAST_IDX = BIW'(NBYTES - 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0]  RETRY_LIM = RW'(MAX_RETRY);

   state_t             r_state;
   state_t             w_next;
   logic [CMD_W-1:0]   r_shift;
   logic [BIW-1:0]     r_byte_idx;
   logic [TW-1:0]      r_timer;
   logic [RW-1:0]      r_retry_cnt;
   logic [7:0]         r_resp;
   logic               r_resp_rdy;
   logic               r_clr_rx_rdy;
   logic               r_cmd_sent;
   logic               r_cmd_fail;
   logic [CMD_W-1:0]   w_head;
   logic               w_empty;
   logic               w_rx_valid;
   logic               w_pop;
   logic               w_load;
   logic               w_shift;
   logic               w_sent;
   logic               w_rsp;
   logic               w_ack;
   logic               w_resend;
   logic               w_fail;

   cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (i_send_cmd),
      .i_pop   (w_pop),
      .i_din   (i_cmd),
      .o_head  (w_head),
      .o_full  (o_cmd_full),
      .o_empty (w_empty),
      .o_ovf   (o_ovf)
   );

   // A byte whose clear is already in flight must not be taken as a second response.
   assign w_rx_valid   = i_rx_rdy & ~r_clr_rx_rdy;
   assign o_cmd_empty  = w_empty;
   assign o_busy       = (r_state != IDLE);
   assign o_trmt       = (r_state == SEND);
   assign o_tx_data    = r_shift[CMD_W-1 -: 8];
   assign o_clr_rx_rdy = r_clr_rx_rdy;
   assign o_cmd_sent   = r_cmd_sent;
   assign o_resp       = r_resp;
   assign o_resp_rdy   = r_resp_rdy;
   assign o_cmd_fail   = r_cmd_fail;

   always_comb begin
      w_next   = r_state;
      w_pop    = 1'b0;
      w_load   = 1'b0;
      w_shift  = 1'b0;
      w_sent   = 1'b0;
      w_rsp    = 1'b0;
      w_ack    = 1'b0;
      w_resend = 1'b0;
      w_fail   = 1'b0;
      case (r_state)
         IDLE:    if (!w_empty) w_next = LOAD;
         LOAD:    begin
                     w_load = 1'b1;
                     w_next = SEND;
                  end
         SEND:    w_next = WAIT_TX;
         WAIT_TX: if (i_tx_done) begin
                     w_shift = 1'b1;
                     if (r_byte_idx == LAST_IDX) begin
                        w_sent = 1'b1;
                        w_next = WAIT_RSP;
                     end else begin
                        w_next = SEND;
                     end
                  end
         WAIT_RSP: if (w_rx_valid) begin
                     w_rsp = 1'b1;
                     if (i_rx_data == ACK_BYTE) begin
                        w_ack  = 1'b1;
                        w_pop  = 1'b1;
                        w_next = IDLE;
                     end else begin
                        w_next = RETRY;
                     end
                  end else if (r_timer == TMO_LAST) begin
                     w_next = RETRY;
                  end
         RETRY:   if (r_retry_cnt < RETRY_LIM) begin
                     w_resend = 1'b1;
                     w_next   = LOAD;
                  end else begin
                     w_fail = 1'b1;
                     w_pop  = 1'b1;
                     w_next = IDLE;
                  end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Shift register, byte/timeout/retry counters and the registered status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift      <= '0;
         r_byte_idx   <= '0;
         r_timer      <= '0;
         r_retry_cnt  <= '0;
         r_resp       <= '0;
         r_resp_rdy   <= 1'b0;
         r_clr_rx_rdy <= 1'b0;
         r_cmd_sent   <= 1'b0;
         r_cmd_fail   <= 1'b0;
      end else begin
         if (w_load) begin
            r_shift    <= w_head;
            r_byte_idx <= '0;
            r_timer    <= '0;
         end else if (w_shift) begin
            r_shift    <= r_shift << 8;
            r_byte_idx <= r_byte_idx + 1'b1;
            if (w_sent) r_timer <= '0;
         end else if (r_state == WAIT_RSP) begin
            r_timer <= r_timer + 1'b1;
         end
         if (w_ack || w_fail) r_retry_cnt <= '0;
         else if (w_resend)   r_retry_cnt <= r_retry_cnt + 1'b1;
         if (w_rsp) r_resp <= i_rx_data;
         r_resp_rdy   <= w_rsp;
         r_clr_rx_rdy <= w_rx_valid;
         r_cmd_sent   <= w_sent;
         r_cmd_fail   <= w_fail;
      end
   end

`ifdef REMOTE_CMD_STATS_EN
   logic [15:0] r_ack_cnt;
   logic [15:0] r_fail_cnt;
   logic [15:0] r_retry_tot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack_cnt   <= '0;
         r_fail_cnt  <= '0;
         r_retry_tot <= '0;
      end else begin
         if (w_ack && r_ack_cnt != 16'hFFFF)      r_ack_cnt   <= r_ack_cnt + 1'b1;
         if (w_fail && r_fail_cnt != 16'hFFFF)    r_fail_cnt  <= r_fail_cnt + 1'b1;
         if (w_resend && r_retry_tot != 16'hFFFF) r_retry_tot <= r_retry_tot + 1'b1;
      end
   end

   assign o_ack_cnt   = r_ack_cnt;
   assign o_fail_cnt  = r_fail_cnt;
   assign o_retry_tot = r_retry_tot;
`endif
endmodule

// File: tb/tb_remote_cmd_seq.sv
// Scoreboard bench for remote_cmd_seq with a behavioural UART (tx_done 10 cycles after trmt).
module tb_remote_cmd_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cmd;
   logic        send_cmd;
   logic        cmd_full, cmd_empty, ovf, busy, trmt;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic [7:0]  rx_data;
   logic        rx_rdy;
   logic        clr_rx_rdy, cmd_sent, resp_rdy, cmd_fail;
   logic [7:0]  resp;
`ifdef REMOTE_CMD_STATS_EN
   logic [15:0] ack_cnt, fail_cnt, retry_tot;
`endif

   remote_cmd_seq #(
      .CMD_W(16), .DEPTH(4), .ACK_BYTE(8'hA5), .TIMEOUT_CYC(64), .MAX_RETRY(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cmd        (cmd),
      .i_send_cmd   (send_cmd),
      .o_cmd_full   (cmd_full),
      .o_cmd_empty  (cmd_empty),
      .o_ovf        (ovf),
      .o_busy       (busy),
      .o_trmt       (trmt),
      .o_tx_data    (tx_data),
      .i_tx_done    (tx_done),
      .i_rx_data    (rx_data),
      .i_rx_rdy     (rx_rdy),
      .o_clr_rx_rdy (clr_rx_rdy),
      .o_cmd_sent   (cmd_sent),
      .o_resp       (resp),
      .o_resp_rdy   (resp_rdy),
      .o_cmd_fail   (cmd_fail)
`ifdef REMOTE_CMD_STATS_EN
      ,
      .o_ack_cnt    (ack_cnt),
      .o_fail_cnt   (fail_cnt),
      .o_retry_tot  (retry_tot)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   logic [7:0] expTxQ[$];
   logic [7:0] expRespQ[$];
   int replyPlanQ[$];
   int gapQ[$];
   int trmtCount = 0, respRdyCount = 0, cmdFailCount = 0, ovfCount = 0, clrCount = 0;
   int txCount = 0, rspDelay = 0, planVal = 0, lastSentCyc = 0;
   bit rspPending = 0, sentSinceTrmt = 0, gapEnable = 0;
   logic [7:0] rspByte = 8'h00;
   int unsolReq = 0, unsolDone = 0;
   int snapA, snapB, snapC, waitN;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // UART model and output monitor: sample DUT outputs first, then update the link inputs.
   always @(negedge clk) begin
      cycle++;
      if (!rst_n) begin
         tx_done = 1'b0;
         txCount = 0;
         rx_rdy = 1'b0;
         rx_data = 8'h00;
         rspPending = 1'b0;
      end else begin
         if (trmt) begin
            trmtCount++;
            if (expTxQ.size() == 0) checkOutput("unexpected_trmt", 32'd1, 32'd0);
            else checkOutput("tx_data", tx_data, expTxQ.pop_front());
            if (sentSinceTrmt) gapQ.push_back(cycle - lastSentCyc);
            sentSinceTrmt = 1'b0;
         end
         if (resp_rdy) begin
            respRdyCount++;
            if (expRespQ.size() == 0) checkOutput("unexpected_resp_rdy", 32'd1, 32'd0);
            else checkOutput("resp", resp, expRespQ.pop_front());
         end
         if (cmd_sent) begin
            lastSentCyc = cycle;
            sentSinceTrmt = gapEnable;
            if (replyPlanQ.size() == 0) checkOutput("unexpected_cmd_sent", 32'd1, 32'd0);
            else begin
               planVal = replyPlanQ.pop_front();
               if (planVal >= 0) begin
                  rspPending = 1'b1;
                  rspDelay = 5;
                  rspByte = planVal[7:0];
               end
            end
         end
         if (cmd_fail) cmdFailCount++;
         if (ovf) ovfCount++;
         if (clr_rx_rdy) begin
            clrCount++;
            rx_rdy = 1'b0;
         end
         tx_done = 1'b0;
         if (txCount > 0) begin
            txCount--;
            if (txCount == 0) tx_done = 1'b1;
         end
         if (trmt) txCount = 10;
         if (rspPending) begin
            rspDelay--;
            if (rspDelay == 0) begin
               rx_rdy = 1'b1;
               rx_data = rspByte;
               rspPending = 1'b0;
            end
         end
         if (unsolReq != unsolDone) begin
            rx_rdy = 1'b1;
            rx_data = 8'h77;
            unsolDone = unsolReq;
         end
      end
   end

   task automatic planReply(input int p);
      replyPlanQ.push_back(p);
      if (p >= 0) expRespQ.push_back(p[7:0]);
   endtask

   task automatic applyStimulus(input logic [15:0] c, input bit accepted);
      @(negedge clk);
      cmd = c;
      send_cmd = 1'b1;
      if (accepted) begin
         expTxQ.push_back(c[15:8]);
         expTxQ.push_back(c[7:0]);
      end
   endtask

   task automatic endPush();
      @(negedge clk);
      send_cmd = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int maxCyc);
      int n = 0;
      while ((busy || !cmd_empty || expTxQ.size() != 0) && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_settled"}, 32'(n < maxCyc), 32'd1);
      repeat (8) @(negedge clk);
      checkOutput({tag, "_resp_drained"}, expRespQ.size(), 32'd0);
      checkOutput({tag, "_plan_drained"}, replyPlanQ.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0;
      send_cmd = 1'b0;
      cmd = 16'h0000;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_trmt", trmt, 0);
      checkOutput("rst_cmd_empty", cmd_empty, 1);
      checkOutput("rst_cmd_full", cmd_full, 0);
      checkOutput("rst_ovf", ovf, 0);
      checkOutput("rst_resp", resp, 0);
      checkOutput("rst_pulses", {resp_rdy, cmd_sent, cmd_fail, clr_rx_rdy}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] single command with ACK");
      planReply(8'hA5);
      applyStimulus(16'hA5C3, 1'b1);
      endPush();
      waitIdle("single", 300);
      checkOutput("single_trmts", trmtCount, 2);
      checkOutput("single_resp_rdy", respRdyCount, 1);
      checkOutput("single_empty", cmd_empty, 1);

      $display("[TB] unsolicited byte while idle");
      snapA = clrCount;
      snapB = respRdyCount;
      unsolReq++;
      repeat (6) @(negedge clk);
      checkOutput("unsol_clr", clrCount - snapA, 1);
      checkOutput("unsol_no_resp_rdy", respRdyCount - snapB, 0);
      checkOutput("unsol_resp_held", resp, 8'hA5);

      $display("[TB] four queued plus one after first ACK");
      snapA = ovfCount;
      snapB = respRdyCount;
      for (int i = 0; i < 5; i++) planReply(8'hA5);
      applyStimulus(16'h0102, 1'b1);
      applyStimulus(16'h0304, 1'b1);
      applyStimulus(16'h0506, 1'b1);
      applyStimulus(16'h0708, 1'b1);
      endPush();
      waitN = 0;
      while (respRdyCount == snapB && waitN < 300) begin
         @(negedge clk);
         waitN++;
      end
      checkOutput("queue_first_ack_seen", 32'(waitN < 300), 1);
      applyStimulus(16'h090A, 1'b1);
      endPush();
      waitIdle("queue", 1000);
      checkOutput("queue_no_ovf", ovfCount - snapA, 0);

      $display("[TB] five back-to-back pushes while idle");
      snapA = ovfCount;
      snapB = trmtCount;
      for (int i = 0; i < 4; i++) planReply(8'hA5);
      applyStimulus(16'h1122, 1'b1);
      applyStimulus(16'h3344, 1'b1);
      applyStimulus(16'h5566, 1'b1);
      applyStimulus(16'h7788, 1'b1);
      @(negedge clk);
      checkOutput("burst_full", cmd_full, 1);
      cmd = 16'h99AA;
      endPush();
      checkOutput("burst_ovf_pulse", ovf, 1);
      waitIdle("burst", 1000);
      checkOutput("burst_ovf_count", ovfCount - snapA, 1);
      checkOutput("burst_trmts", trmtCount - snapB, 8);

      $display("[TB] NAK then ACK");
      snapA = cmdFailCount;
      planReply(8'h00);
      planReply(8'hA5);
      applyStimulus(16'hBEEF, 1'b1);
      expTxQ.push_back(8'hBE);
      expTxQ.push_back(8'hEF);
      endPush();
      waitIdle("nak", 500);
      checkOutput("nak_no_fail", cmdFailCount - snapA, 0);
      checkOutput("nak_resp", resp, 8'hA5);

      $display("[TB] no reply, timeout retries");
      snapA = cmdFailCount;
      snapB = trmtCount;
      gapEnable = 1'b1;
      for (int i = 0; i < 3; i++) planReply(-1);
      applyStimulus(16'hDEAD, 1'b1);
      for (int i = 0; i < 2; i++) begin
         expTxQ.push_back(8'hDE);
         expTxQ.push_back(8'hAD);
      end
      endPush();
      waitIdle("timeout", 2000);
      gapEnable = 1'b0;
      checkOutput("timeout_fail", cmdFailCount - snapA, 1);
      checkOutput("timeout_trmts", trmtCount - snapB, 6);
      checkOutput("timeout_empty", cmd_empty, 1);
      checkOutput("timeout_gap_count", gapQ.size(), 2);
      for (int i = 0; i < 2 && i < gapQ.size(); i++)
         checkOutput("timeout_gap_window", 32'(gapQ[i] >= 60 && gapQ[i] <= 72), 1);

`ifdef REMOTE_CMD_STATS_EN
      checkOutput("stats_ack", ack_cnt, 11);
      checkOutput("stats_fail", fail_cnt, 1);
      checkOutput("stats_retry", retry_tot, 3);
`endif

      $display("[TB] reset during transfer");
      snapB = trmtCount;
      applyStimulus(16'h1234, 1'b0);
      expTxQ.push_back(8'h12);
      endPush();
      waitN = 0;
      while (trmtCount == snapB && waitN < 20) begin
         @(negedge clk);
         waitN++;
      end
      checkOutput("rst_mid_first_byte", 32'(waitN < 20), 1);
      repeat (3) @(negedge clk);
      checkOutput("rst_mid_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_trmt", trmt, 0);
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_empty", cmd_empty, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      snapC = trmtCount;
      repeat (100) @(negedge clk);
      checkOutput("rst_mid_no_sends", trmtCount - snapC, 0);
      checkOutput("rst_mid_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
